// File: rtl/axis_pkg.sv
// Shared helpers for the narrow-to-wide stream packer.
// Width, lane-count and keep-mask utilities.
package axis_pkg;

  localparam int PACKER_DATA_WIDTH = 8;
  localparam int PACKER_RATIO = 4;

  typedef logic [$clog2(PACKER_RATIO)-1:0] lane_cnt_t;

  function automatic int packer_out_w(
    input int dw,
    input int ratio
  );
    return dw * ratio;
  endfunction

  function automatic int packer_cnt_w(
    input int ratio
  );
    return $clog2(ratio);
  endfunction

  function automatic logic [63:0] keep_mask(
    input int lanes
  );
    if (lanes >= 64) return '1;
    return (64'd1 << lanes) - 64'd1;
  endfunction

endpackage

// File: rtl/axis_width_packer_if.sv
// Narrow-in / wide-out stream bundle for axis_width_packer.
// last_in/last_out/keep_out exist only with AXIS_PACKER_LAST_EN.
interface axis_width_packer_if
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO = 4
);

  logic valid_in;
  logic [DATA_WIDTH-1:0] data_in;
  logic ready_out;
  logic valid_out;
  logic [packer_out_w(DATA_WIDTH, RATIO)-1:0] data_out;
  logic ready_in;
`ifdef AXIS_PACKER_LAST_EN
  logic last_in;
  logic last_out;
  logic [RATIO-1:0] keep_out;
`endif

  modport slave (
    input  valid_in,
    input  data_in,
    output ready_out,
    output valid_out,
    output data_out,
`ifdef AXIS_PACKER_LAST_EN
    input  last_in,
    output last_out,
    output keep_out,
`endif
    input  ready_in
  );

  modport master (
    output valid_in,
    output data_in,
    input  ready_out,
    input  valid_out,
    input  data_out,
`ifdef AXIS_PACKER_LAST_EN
    output last_in,
    input  last_out,
    input  keep_out,
`endif
    output ready_in
  );

endinterface

// File: rtl/axis_width_packer.sv
// Packs RATIO narrow beats into one wide word, first beat in LSBs.
// AXIS_PACKER_LAST_EN adds last-terminated partial words with keep.
module axis_width_packer
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RATIO = 4
) (
  input logic clk,
  input logic reset,
  axis_width_packer_if.slave bus
);

  localparam int OUT_W = packer_out_w(DATA_WIDTH, RATIO);
  localparam int CW = packer_cnt_w(RATIO);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t LAST_LANE = cnt_t'(RATIO - 1);

  cnt_t count;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] word;
  logic accept;
  logic full;
  logic done;
  logic take;

  assign full = (count == LAST_LANE);
  assign take = bus.valid_out & bus.ready_in;
  assign accept = bus.valid_in & bus.ready_out;

`ifdef AXIS_PACKER_LAST_EN
  // Any beat may complete a word, so every beat needs room downstream.
  assign bus.ready_out = ~bus.valid_out | bus.ready_in;
  assign done = accept & (full | bus.last_in);
`else
  assign bus.ready_out = ~full | ~bus.valid_out | bus.ready_in;
  assign done = accept & full;
`endif

  always_comb begin
    word = acc;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt_t'(k) == count)
        word[k*DATA_WIDTH +: DATA_WIDTH] = bus.data_in;
`ifdef AXIS_PACKER_LAST_EN
      else if (cnt_t'(k) > count)
        word[k*DATA_WIDTH +: DATA_WIDTH] = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      acc <= '0;
      bus.valid_out <= 1'b0;
      bus.data_out <= '0;
`ifdef AXIS_PACKER_LAST_EN
      bus.last_out <= 1'b0;
      bus.keep_out <= '0;
`endif
    end else begin
      if (accept) begin
        acc <= word;
        count <= done ? '0 : count + cnt_t'(1);
      end
      if (done) begin
        bus.valid_out <= 1'b1;
        bus.data_out <= word;
`ifdef AXIS_PACKER_LAST_EN
        bus.last_out <= bus.last_in;
        bus.keep_out <= RATIO'(keep_mask(int'(count) + 1));
`endif
      end else if (take) begin
        bus.valid_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_width_packer.sv
// Randomised scoreboard bench for axis_width_packer (8-bit x 4).
// Build with AXIS_PACKER_LAST_EN to exercise last/keep.
module tb_axis_width_packer;

  localparam int DW = 8;
  localparam int R = 4;

  typedef struct {
    logic [31:0] data;
    logic [3:0] keep;
    logic last;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  bit bench_done = 1'b0;

  exp_t exp_q[$];
  logic [7:0] pend[$];

  axis_width_packer_if #(.DATA_WIDTH(DW), .RATIO(R)) bus ();

  axis_width_packer #(.DATA_WIDTH(DW), .RATIO(R)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] d, input bit l,
                       input bit r, output bit acc);
    @(negedge clk);
    bus.valid_in = v;
    bus.data_in = d;
    bus.ready_in = r;
`ifdef AXIS_PACKER_LAST_EN
    bus.last_in = l;
`endif
    #3;
    acc = v & bus.ready_out;
  endtask

  task automatic send(input logic [7:0] d, input bit l, input int rmode);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 200) begin
      drive(1'b1, d, l, rmode == 2 ? ($urandom_range(0, 2) != 0) : rmode[0],
            acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat 0x%0h not accepted in %0d cycles",
               d, n);
    end
  endtask

  task automatic idle(input int n, input bit r);
    bit acc;
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b0, r, acc);
  endtask

  task automatic do_reset();
    bit acc;
    @(negedge clk);
    reset = 1'b1;
    idle(2, 1'b1);
    @(negedge clk);
    reset = 1'b0;
    bus.valid_in = 1'b0;
    #4;
    check("reset_valid_out", 32'(bus.valid_out), 32'd0);
    check("reset_data_out", bus.data_out, 32'd0);
    check("reset_ready_out", 32'(bus.ready_out), 32'd1);
`ifdef AXIS_PACKER_LAST_EN
    check("reset_last_out", 32'(bus.last_out), 32'd0);
    check("reset_keep_out", 32'(bus.keep_out), 32'd0);
`endif
    acc = 1'b0;
  endtask

  // Reference model and monitor: sampled late in each cycle.
  initial begin : monitor
    bit prev_stall;
    logic [31:0] prev_data;
    logic [3:0] prev_keep;
    bit prev_last;
    exp_t e;
    logic [31:0] w;
    bit lst;
    prev_stall = 1'b0;
    prev_data = '0;
    prev_keep = '0;
    prev_last = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (prev_stall) begin
        check("stall_valid_hold", 32'(bus.valid_out), 32'd1);
        check("stall_data_hold", bus.data_out, prev_data);
`ifdef AXIS_PACKER_LAST_EN
        check("stall_keep_hold", 32'(bus.keep_out), 32'(prev_keep));
        check("stall_last_hold", 32'(bus.last_out), 32'(prev_last));
`endif
      end
      prev_stall = !reset && bus.valid_out && !bus.ready_in;
      prev_data = bus.data_out;
`ifdef AXIS_PACKER_LAST_EN
      prev_keep = bus.keep_out;
      prev_last = bus.last_out;
`endif
      if (reset) begin
        pend.delete();
        exp_q.delete();
      end else begin
        if (bus.valid_in && bus.ready_out) begin
          pend.push_back(bus.data_in);
          lst = 1'b0;
`ifdef AXIS_PACKER_LAST_EN
          lst = bus.last_in;
`endif
          if (pend.size() == R || lst) begin
            w = 0;
            for (int i = 0; i < pend.size(); i++)
              w = w | (32'(pend[i]) << (8 * i));
            e.data = w;
            e.keep = 4'((1 << pend.size()) - 1);
            e.last = lst;
            exp_q.push_back(e);
            pend.delete();
          end
        end
        if (bus.valid_out && bus.ready_in) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got 0x%0h expected none",
                     bus.data_out);
          end else begin
            e = exp_q.pop_front();
            check("word_data", bus.data_out, e.data);
`ifdef AXIS_PACKER_LAST_EN
            check("word_keep", 32'(bus.keep_out), 32'(e.keep));
            check("word_last", 32'(bus.last_out), 32'(e.last));
`endif
          end
        end
      end
    end
  end

  initial begin : stim
    bit acc;
    int stalls;
    bus.valid_in = 1'b0;
    bus.data_in = '0;
    bus.ready_in = 1'b1;
`ifdef AXIS_PACKER_LAST_EN
    bus.last_in = 1'b0;
`endif
    do_reset();

    // Back-to-back word with latency check.
    send(8'h11, 1'b0, 1);
    send(8'h22, 1'b0, 1);
    send(8'h33, 1'b0, 1);
    send(8'h44, 1'b0, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, acc);
    check("t1_valid_latency", 32'(bus.valid_out), 32'd1);
    check("t1_data", bus.data_out, 32'h44332211);
    idle(2, 1'b1);

    // Held output word with back-pressure.
    for (int i = 0; i < 4; i++) send(8'h51 + 8'(i), 1'b0, 0);
`ifndef AXIS_PACKER_LAST_EN
    for (int i = 0; i < 3; i++) send(8'h61 + 8'(i), 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h64, 1'b0, 1'b0, acc);
      check("t2_stall_4th", 32'(acc), 32'd0);
    end
    drive(1'b1, 8'h64, 1'b0, 1'b1, acc);
    check("t2_accept_on_release", 32'(acc), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, acc);
    check("t2_valid_kept", 32'(bus.valid_out), 32'd1);
    check("t2_new_word", bus.data_out, 32'h64636261);
`else
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'h61, 1'b0, 1'b0, acc);
      check("t2_stall_hold", 32'(acc), 32'd0);
    end
`endif
    idle(3, 1'b1);

    // Streaming at full rate.
    stalls = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 8'(i), 1'b0, 1'b1, acc);
      if (!acc) stalls++;
    end
    check("t3_no_stall", 32'(stalls), 32'd0);
    idle(3, 1'b1);

    // Reset mid-word discards residue.
    send(8'hE1, 1'b0, 1);
    send(8'hE2, 1'b0, 1);
    do_reset();
    for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), 1'b0, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, acc);
    check("t4_clean_word", bus.data_out, 32'hA3A2A1A0);
    idle(2, 1'b1);

`ifdef AXIS_PACKER_LAST_EN
    send(8'hAA, 1'b0, 1);
    send(8'hBB, 1'b1, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, acc);
    check("t5_data", bus.data_out, 32'h0000BBAA);
    check("t5_keep", 32'(bus.keep_out), 32'h3);
    check("t5_last", 32'(bus.last_out), 32'd1);
    idle(1, 1'b1);
    for (int i = 0; i < 4; i++) send(8'hC0 + 8'(i), 1'b0, 1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, acc);
    check("t5_next_lane0", bus.data_out, 32'hC3C2C1C0);
    check("t5_next_keep", 32'(bus.keep_out), 32'hF);
    idle(2, 1'b1);
`endif

    // Random gaps and back-pressure.
    for (int i = 0; i < 1000; i++) begin
      bit l;
      l = 1'b0;
`ifdef AXIS_PACKER_LAST_EN
      l = ($urandom_range(0, 6) == 0);
`endif
      if ($urandom_range(0, 3) == 0)
        idle($urandom_range(1, 3), $urandom_range(0, 1) != 0);
      send(8'($urandom), l, 2);
    end
    // Finish any partial word so the drain is deterministic.
    while (pend.size() != 0) send(8'($urandom), 1'b0, 1);
    idle(10, 1'b1);
    check("drain_empty", 32'(exp_q.size()), 32'd0);

    bench_done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    if (!bench_done) begin
      $display("FAIL watchdog: bench did not finish, %0d checks %0d errors",
               checks, errors);
      $fatal(1, "timeout");
    end
  end

endmodule
